// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator.
//   redir_kind_e     : contents of the single pending-redirect slot
//   RESET_PC_DEFAULT : default PC loaded by reset
//   INC_DEFAULT      : default sequential step (bytes)
package pc_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        EXC    = 2'd2
    } redir_kind_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          INC_DEFAULT      = 4;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack, circular buffer. Pushing onto a full stack
// overwrites the oldest entry; depth saturates at DEPTH.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : empty the stack at this edge
//   push, pop       : push push_data / pop top entry (pop ignored while empty)
//   push_data       : value to push
//   top             : current top entry (undefined while empty)
//   empty           : no entries held
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   tos;
    logic [PW-1:0]   tos_inc;
    logic [PW-1:0]   tos_dec;
    logic [CW-1:0]   count;
    logic            pop_ok;

    assign tos_inc = tos + PW'(1);
    assign tos_dec = tos - PW'(1);
    assign pop_ok  = pop && (count != '0);
    assign top     = mem[tos];
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            tos   <= '0;
            count <= '0;
        end else if (push && pop_ok) begin
            // Pop then push: top is replaced in place, depth unchanged.
            tos   <= tos;
            count <= count;
        end else if (push) begin
            tos <= tos_inc;
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop_ok) begin
            tos   <= tos_dec;
            count <= count - CW'(1);
        end
    end

    // Storage carries no reset; entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push && pop_ok) begin
                mem[tos] <= push_data;
            end else if (push) begin
                mem[tos_inc] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with a single pending-redirect slot and an
// optional return-address stack (enabled by defining PC_GEN_RAS_EN).
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   stall                   : hold pc; redirects are latched into the slot
//   br_valid, br_target     : branch/jump redirect
//   exc_valid, exc_vector   : exception redirect
//   call, ret               : call/return hints for the current pc
//   pc                      : current pc (registered)
//   pc_next                 : value pc takes at the next non-stall edge
//   redir_pending           : a redirect is latched, waiting for stall to drop
//   ras_empty               : return-address stack is empty (1 without RAS)
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
    parameter int              INC       = INC_DEFAULT,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_vector,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            redir_pending,
    output logic            ras_empty
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC) - XLEN'(1));

    redir_kind_e     pend_kind;
    logic [XLEN-1:0] pend_tgt;
    logic [XLEN-1:0] br_al;
    logic [XLEN-1:0] exc_al;
    logic [XLEN-1:0] pc_seq;
    logic            exc_win;
    logic            br_win;
    logic            ras_take;
    logic [XLEN-1:0] ras_top;

    assign br_al   = br_target & ALIGN_MASK;
    assign exc_al  = exc_vector & ALIGN_MASK;
    assign pc_seq  = pc + XLEN'(INC);
    assign exc_win = exc_valid || (pend_kind == EXC);
    assign br_win  = !exc_win && (br_valid || (pend_kind == BRANCH));

    assign redir_pending = (pend_kind != NONE);

`ifdef PC_GEN_RAS_EN
    logic ras_empty_int;
    logic ras_push;
    logic ras_pop;
    logic ras_flush;

    // Hints only count when no redirect wins this cycle.
    assign ras_take  = !exc_win && !br_win && ret && !ras_empty_int;
    assign ras_pop   = !stall && ras_take;
    assign ras_push  = !stall && !exc_win && !br_win && call;
    assign ras_flush = !stall && exc_win;
    assign ras_empty = ras_empty_int;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .flush     (ras_flush),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq & ALIGN_MASK),
        .top       (ras_top),
        .empty     (ras_empty_int)
    );
`else
    logic unused_hints;

    assign unused_hints = call ^ ret;
    assign ras_take     = 1'b0;
    assign ras_top      = '0;
    assign ras_empty    = 1'b1;
`endif

    always_comb begin
        pc_next = pc_seq;
        if (exc_valid) begin
            pc_next = exc_al;
        end else if (pend_kind == EXC) begin
            pc_next = pend_tgt;
        end else if (br_valid) begin
            pc_next = br_al;
        end else if (pend_kind == BRANCH) begin
            pc_next = pend_tgt;
        end else if (ras_take) begin
            pc_next = ras_top;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            pend_kind <= NONE;
            pend_tgt  <= '0;
        end else if (stall) begin
            // Exception always takes the slot; a branch never displaces one.
            if (exc_valid) begin
                pend_kind <= EXC;
                pend_tgt  <= exc_al;
            end else if (br_valid && (pend_kind != EXC)) begin
                pend_kind <= BRANCH;
                pend_tgt  <= br_al;
            end
        end else begin
            pc        <= pc_next;
            pend_kind <= NONE;
        end
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: PC width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_3000: PC value after reset.
REQ-003 Parameter INC, default 4: sequential step; power of two, at least 1.
REQ-004 Parameter RAS_DEPTH, default 4: return-address stack entries; power of two, at least 2.
REQ-005 clk  in  1: single clock; all state updates on the rising edge.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 stall  in  1: when high, PC holds its value.
REQ-008 br_valid  in  1; br_target  in  XLEN: branch/jump redirect request.
REQ-009 exc_valid  in  1; exc_vector  in  XLEN: exception redirect request.
REQ-010 call  in  1; ret  in  1: call/return hints for the current PC.
REQ-011 pc  out  XLEN: current PC, registered.
REQ-012 pc_next  out  XLEN: combinational value pc loads at the next non-stall edge.
REQ-013 redir_pending  out  1: a redirect is latched and waiting for stall to drop.
REQ-014 ras_empty  out  1: return-address stack holds no entries.

Function
REQ-015 Targets are aligned: the low log2(INC) bits of br_target, exc_vector and RAS entries are forced to zero.
REQ-016 Sequential PC is pc+INC modulo 2^XLEN; all-ones wraps to 0 with no flag.
REQ-017 Non-stall cycle selection priority, highest first: live exc_valid; pending exception; live br_valid; pending branch; ret with RAS non-empty; sequential.
REQ-018 Stall cycle: pc is unchanged, and any redirect is latched into the single pending slot.
REQ-019 Pending slot rules: an exception always overwrites the slot; a branch overwrites only an empty slot or one holding a branch; a branch never displaces a pending exception.
REQ-020 The pending slot is cleared on the first non-stall edge, regardless of which source wins; redir_pending is low in the following cycle.
REQ-021 Latency: a redirect asserted in a non-stall cycle appears on pc exactly one edge later; a latched redirect appears on pc one edge after stall falls.
REQ-022 call/ret are sampled only in non-stall cycles when no exception or branch (live or pending) wins.
REQ-023 Push on call: value pc+INC. When the stack is full, it overwrites the oldest entry as a circular buffer; depth saturates at RAS_DEPTH.
REQ-024 Pop on ret when non-empty: pc loads the top entry. ret while empty is ignored, and pc follows sequential.
REQ-025 call and ret in the same cycle: pop to pc first, then push pc+INC. Net effect: the top entry is replaced and depth is unchanged.
REQ-026 Any winning exception (live or pending) flushes the RAS to empty at that edge.

Reset
REQ-027 On rst high at an edge: pc=RESET_PC, pending slot cleared, redir_pending=0, RAS empty, ras_empty=1.
REQ-028 rst overrides stall, redirects and call/ret in the same cycle.
REQ-029 Reset during a pending redirect discards that redirect.

Configuration
REQ-030 Macro PC_GEN_RAS_EN: when defined, REQ-022 to REQ-026 apply.
REQ-031 Without PC_GEN_RAS_EN: no stack storage, call/ret ignored, ras_empty tied to 1. Exceptions still follow REQ-017 to REQ-021.

Structure
REQ-032 Shared package pc_pkg holds:
- redirect-kind enum: NONE, BRANCH, EXC
- RESET_PC default constant
- INC default constant
REQ-033 The RAS is a sub-module pc_ras with ports push, pop, push_data, top, empty, and the circular overwrite logic. pc_gen instantiates it only under PC_GEN_RAS_EN.

Verification
REQ-034 Sequential and wrap:
- Release rst and run 3 cycles -> pc = 0x3000, 0x3004, 0x3008.
- Force pc=0xFFFF_FFFC and take one step -> pc = 0x0000_0000.
REQ-035 Priority: exc_valid (0x8000_0000) and br_valid (0x4000) asserted in the same cycle -> pc=0x8000_0000; br_target 0x4003 -> pc=0x4000.
REQ-036 Stall latch:
- stall high 3 cycles with br_valid=0x5000 in cycle 1 -> pc held, redir_pending=1; stall falls -> pc=0x5000, redir_pending=0.
- As above, plus exc_valid=0x100 in cycle 2 -> pc=0x100.
REQ-037 RAS, with PC_GEN_RAS_EN defined:
- call at pc=0x3000 -> push 0x3004; br to 0x6000; ret -> pc=0x3004, ras_empty=1.
- Five calls with RAS_DEPTH=4 -> four rets return the 2nd to 5th return addresses; the fifth ret is sequential.
REQ-038 Reset mid-operation: rst while redir_pending=1 with 2 RAS entries -> next pc=0x3000, redir_pending=0, ras_empty=1; the pending target never appears.
REQ-039 Without PC_GEN_RAS_EN: a call then ret sequence -> pc purely sequential, ras_empty=1 throughout.
